// File: rtl/entering_uranus.sv
// -----------------------------------------------------------------------------
// entering_uranus
//
// Inbound airlock sequencer. It walks an arriving astronaut through
// evacuate -> outer door -> pressurize -> inner door and back to idle. It has
// its own tick prescaler and seconds counter, so no external timebase is
// needed. The permission flags are ANDed at the top level with those of the
// outbound controller.
//
// Ports
//   clock       system clock; all state changes happen on its rising edge
//   rst         synchronous, active-high reset
//   innerPort   1 = inner door open
//   outerPort   1 = outer door open
//   arriving    arrival request switch (level)
//   evac        evacuate button (level, sampled only in IDLE)
//   pressurize  pressurize button (level, sampled only in PRESS_READY)
//   canOut      outer door may be opened
//   canIn       inner door may be opened
//   busy        sequence in progress (state is not IDLE)
//   display     active-low 7-segment digit {g..a}
//   stateDbg    registered FSM state, for observation only:
//               0 IDLE, 1 EVAC_T, 2 OUTER_READY, 3 OUTER_OPEN,
//               4 PRESS_READY, 5 PRESS_T, 6 INNER_READY, 7 INNER_OPEN
//
// Configuration macro
//   ENTER_ABORT_EN  when defined, dropping arriving during EVAC_T returns the
//                   block to IDLE on the next edge. When undefined, arriving
//                   is ignored in EVAC_T and the evacuation always completes.
// -----------------------------------------------------------------------------
module entering_uranus #(
   parameter int TICKS_PER_SEC = 50000000,
   parameter int EVAC_SECS     = 7,
   parameter int PRESS_SECS    = 8
) (
   input  logic       clock,
   input  logic       rst,
   input  logic       innerPort,
   input  logic       outerPort,
   input  logic       arriving,
   input  logic       evac,
   input  logic       pressurize,
   output logic       canOut,
   output logic       canIn,
   output logic       busy,
   output logic [6:0] display,
   output logic [2:0] stateDbg
);

   // A one-tick-per-second configuration still needs a 1-bit counter.
   localparam int TW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_E     = 7'b0000110;
   localparam logic [6:0] SEG_P     = 7'b0001100;
   localparam logic [6:0] SEG_A     = 7'b0001000;

   typedef enum logic [2:0] {
      IDLE        = 3'd0,
      EVAC_T      = 3'd1,
      OUTER_READY = 3'd2,
      OUTER_OPEN  = 3'd3,
      PRESS_READY = 3'd4,
      PRESS_T     = 3'd5,
      INNER_READY = 3'd6,
      INNER_OPEN  = 3'd7
   } state_t;

   state_t        state;
   state_t        nextState;
   logic [TW-1:0] tickCnt;
   logic [3:0]    secCnt;
   logic          tickLast;
   logic          evacDone;
   logic          pressDone;
   logic          inTimer;
   logic          doorsClosed;

   assign tickLast    = (tickCnt == TW'(TICKS_PER_SEC - 1));
   assign evacDone    = tickLast && (secCnt == 4'(EVAC_SECS - 1));
   assign pressDone   = tickLast && (secCnt == 4'(PRESS_SECS - 1));
   assign inTimer     = (state == EVAC_T) || (state == PRESS_T);
   assign doorsClosed = ~outerPort & ~innerPort;

   // State register.
   always_ff @(posedge clock) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Timebase. Counters sit at zero outside the timer states and are cleared
   // on any state change, so every timer phase starts from zero and lasts
   // exactly N*TICKS_PER_SEC cycles.
   always_ff @(posedge clock) begin
      if (rst || !inTimer || (nextState != state)) begin
         tickCnt <= '0;
         secCnt  <= '0;
      end else if (tickLast) begin
         tickCnt <= '0;
         secCnt  <= secCnt + 4'd1;
      end else begin
         tickCnt <= tickCnt + TW'(1);
      end
   end

   // Next-state logic. Anything not listed holds the state.
   always_comb begin
      nextState = state;
      case (state)
         IDLE: begin
            if (arriving && evac && doorsClosed) nextState = EVAC_T;
         end
         EVAC_T: begin
`ifdef ENTER_ABORT_EN
            if (!arriving)     nextState = IDLE;
            else if (evacDone) nextState = OUTER_READY;
`else
            if (evacDone) nextState = OUTER_READY;
`endif
         end
         OUTER_READY: begin
            if (outerPort && !innerPort) nextState = OUTER_OPEN;
         end
         OUTER_OPEN: begin
            if (doorsClosed) nextState = PRESS_READY;
         end
         PRESS_READY: begin
            if (pressurize && doorsClosed) nextState = PRESS_T;
         end
         PRESS_T: begin
            if (pressDone) nextState = INNER_READY;
         end
         INNER_READY: begin
            if (innerPort && !outerPort) nextState = INNER_OPEN;
         end
         INNER_OPEN: begin
            if (doorsClosed && !arriving) nextState = IDLE;
         end
         default: nextState = IDLE;
      endcase
   end

   // Moore output decode from the registered state only.
   always_comb begin
      canOut  = 1'b0;
      canIn   = 1'b1;
      display = SEG_BLANK;
      case (state)
         IDLE: begin
            canOut  = 1'b0;
            canIn   = 1'b1;
            display = SEG_BLANK;
         end
         EVAC_T: begin
            canIn   = 1'b0;
            display = SEG_E;
         end
         OUTER_READY, OUTER_OPEN: begin
            canOut  = 1'b1;
            canIn   = 1'b0;
         end
         PRESS_READY: begin
            canIn   = 1'b0;
         end
         PRESS_T: begin
            canIn   = 1'b0;
            display = SEG_P;
         end
         INNER_READY, INNER_OPEN: begin
            canIn   = 1'b1;
            display = SEG_A;
         end
         default: begin
            canOut  = 1'b0;
            canIn   = 1'b1;
            display = SEG_BLANK;
         end
      endcase
   end

   assign busy     = (state != IDLE);
   assign stateDbg = state;

endmodule

// File: tb/tb_entering_uranus.sv
// Bench for entering_uranus with TICKS_PER_SEC=4, EVAC_SECS=7, PRESS_SECS=8.
// Observed vector: {stateDbg[2:0], busy, canOut, canIn, display[6:0]}.
module tb_entering_uranus;

  localparam int W = 13;

  // Expected observation vectors per state.
  localparam logic [W-1:0] X_IDLE   = {3'd0, 1'b0, 1'b0, 1'b1, 7'b1111111};
  localparam logic [W-1:0] X_EVAC   = {3'd1, 1'b1, 1'b0, 1'b0, 7'b0000110};
  localparam logic [W-1:0] X_OREADY = {3'd2, 1'b1, 1'b1, 1'b0, 7'b1111111};
  localparam logic [W-1:0] X_OOPEN  = {3'd3, 1'b1, 1'b1, 1'b0, 7'b1111111};
  localparam logic [W-1:0] X_PREADY = {3'd4, 1'b1, 1'b0, 1'b0, 7'b1111111};
  localparam logic [W-1:0] X_PRESS  = {3'd5, 1'b1, 1'b0, 1'b0, 7'b0001100};
  localparam logic [W-1:0] X_IREADY = {3'd6, 1'b1, 1'b0, 1'b1, 7'b0001000};
  localparam logic [W-1:0] X_IOPEN  = {3'd7, 1'b1, 1'b0, 1'b1, 7'b0001000};

  // ---------------- clock / reset / DUT ----------------
  logic       clock = 1'b0;
  logic       rst = 1'b1;
  logic       innerPort = 1'b0;
  logic       outerPort = 1'b0;
  logic       arriving = 1'b0;
  logic       evac = 1'b0;
  logic       pressurize = 1'b0;
  logic       canOut;
  logic       canIn;
  logic       busy;
  logic [6:0] display;
  logic [2:0] stateDbg;

  always #5 clock = ~clock;

  entering_uranus #(
    .TICKS_PER_SEC(4),
    .EVAC_SECS(7),
    .PRESS_SECS(8)
  ) dut (
    .clock(clock),
    .rst(rst),
    .innerPort(innerPort),
    .outerPort(outerPort),
    .arriving(arriving),
    .evac(evac),
    .pressurize(pressurize),
    .canOut(canOut),
    .canIn(canIn),
    .busy(busy),
    .display(display),
    .stateDbg(stateDbg)
  );

  logic [W-1:0] obs;
  assign obs = {stateDbg, busy, canOut, canIn, display};

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp;
  int checks = 0;
  int failures = 0;

  // Advance one rising edge and sample 1 time unit later.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    {innerPort, outerPort, arriving, evac, pressurize} = '0;
    exp_q.push_back(X_IDLE);
    tick();
    tick();
    exp = exp_q.pop_front();
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL reset_state got=%h exp=%h", obs, exp);
    end
    rst = 1'b0;
  endtask

  // Start held through the last reset edge: leaves IDLE on the first free edge.
  task automatic test_start_during_reset();
    rst = 1'b1;
    arriving = 1'b1;
    evac = 1'b1;
    exp_q.push_back(X_IDLE);
    tick();
    exp = exp_q.pop_front();
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL start_in_reset_hold got=%h exp=%h", obs, exp);
    end
    rst = 1'b0;
    exp_q.push_back(X_EVAC);
    tick();
    exp = exp_q.pop_front();
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL start_after_reset got=%h exp=%h", obs, exp);
    end
    rst = 1'b1;
    evac = 1'b0;
    arriving = 1'b0;
    exp_q.push_back(X_IDLE);
    tick();
    exp = exp_q.pop_front();
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL reset_from_evac got=%h exp=%h", obs, exp);
    end
    rst = 1'b0;
  endtask

  // Full 28-cycle evacuation from IDLE. evac stays high throughout and a
  // premature outer-door open in the middle must be ignored.
  task automatic test_evac_timing();
    arriving = 1'b1;
    evac = 1'b1;
    exp_q.push_back(X_EVAC);
    tick();
    exp = exp_q.pop_front();
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL evac_start got=%h exp=%h", obs, exp);
    end
    for (int i = 1; i < 28; i++) begin
      outerPort = (i >= 3 && i <= 5);
      pressurize = (i == 8);
      exp_q.push_back(X_EVAC);
      tick();
      exp = exp_q.pop_front();
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL evac_hold cyc=%0d got=%h exp=%h", i, obs, exp);
      end
    end
    outerPort = 1'b0;
    pressurize = 1'b0;
    exp_q.push_back(X_OREADY);
    tick();
    exp = exp_q.pop_front();
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL evac_done got=%h exp=%h", obs, exp);
    end
    evac = 1'b0;
  endtask

  // OUTER_READY -> OUTER_OPEN -> PRESS_READY, with wrong-order door inputs.
  task automatic test_outer_doors();
    logic [2:0] pat [5];
    logic [W-1:0] want [5];
    // {outerPort, innerPort, unused}
    pat[0] = 3'b010; want[0] = X_OREADY;  // inner only: ignored
    pat[1] = 3'b110; want[1] = X_OREADY;  // both open: hold
    pat[2] = 3'b100; want[2] = X_OOPEN;
    pat[3] = 3'b110; want[3] = X_OOPEN;   // not both closed: hold
    pat[4] = 3'b000; want[4] = X_PREADY;
    for (int i = 0; i < 5; i++) begin
      outerPort = pat[i][2];
      innerPort = pat[i][1];
      exp_q.push_back(want[i]);
      tick();
      exp = exp_q.pop_front();
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL outer_doors step=%0d got=%h exp=%h", i, obs, exp);
      end
    end
  endtask

  // PRESS_READY -> 32-cycle PRESS_T -> INNER_READY -> INNER_OPEN -> IDLE.
  task automatic test_press_and_inner();
    outerPort = 1'b1;
    pressurize = 1'b1;
    exp_q.push_back(X_PREADY);  // door open blocks pressurize
    tick();
    exp = exp_q.pop_front();
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL press_blocked got=%h exp=%h", obs, exp);
    end
    outerPort = 1'b0;
    exp_q.push_back(X_PRESS);
    tick();
    exp = exp_q.pop_front();
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL press_start got=%h exp=%h", obs, exp);
    end
    pressurize = 1'b0;
    for (int i = 1; i < 32; i++) begin
      innerPort = (i == 12);
      exp_q.push_back(X_PRESS);
      tick();
      exp = exp_q.pop_front();
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL press_hold cyc=%0d got=%h exp=%h", i, obs, exp);
      end
    end
    innerPort = 1'b0;
    exp_q.push_back(X_IREADY);
    tick();
    exp = exp_q.pop_front();
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL press_done got=%h exp=%h", obs, exp);
    end
    begin
      logic [2:0] pat [5];
      logic [W-1:0] want [5];
      // {outerPort, innerPort, arriving}
      pat[0] = 3'b111; want[0] = X_IREADY;  // both doors: hold
      pat[1] = 3'b011; want[1] = X_IOPEN;
      pat[2] = 3'b001; want[2] = X_IOPEN;   // still arriving: hold
      pat[3] = 3'b010; want[3] = X_IOPEN;   // door still open: hold
      pat[4] = 3'b000; want[4] = X_IDLE;
      for (int i = 0; i < 5; i++) begin
        outerPort = pat[i][2];
        innerPort = pat[i][1];
        arriving  = pat[i][0];
        exp_q.push_back(want[i]);
        tick();
        exp = exp_q.pop_front();
        checks++;
        if (obs !== exp) begin
          failures++;
          $display("FAIL inner_doors step=%0d got=%h exp=%h", i, obs, exp);
        end
      end
    end
  endtask

  // Inputs in IDLE that must not start a sequence.
  task automatic test_wrong_order_idle();
    logic [4:0] pat [6];
    // {arriving, evac, pressurize, outerPort, innerPort}
    pat[0] = 5'b00100;
    pat[1] = 5'b11001;
    pat[2] = 5'b11010;
    pat[3] = 5'b01000;
    pat[4] = 5'b10100;
    pat[5] = 5'b11011;
    for (int i = 0; i < 6; i++) begin
      {arriving, evac, pressurize, outerPort, innerPort} = pat[i];
      exp_q.push_back(X_IDLE);
      tick();
      exp = exp_q.pop_front();
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL idle_ignore pat=%0d got=%h exp=%h", i, obs, exp);
      end
    end
    {arriving, evac, pressurize, outerPort, innerPort} = '0;
  endtask

  // Reset at cycle 10 of PRESS_T, then a clean full-length evacuation.
  task automatic test_reset_mid_press();
    test_evac_timing();
    test_outer_doors();
    pressurize = 1'b1;
    for (int i = 0; i <= 10; i++) begin
      exp_q.push_back(X_PRESS);
      tick();
      pressurize = 1'b0;
      exp = exp_q.pop_front();
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL press_pre_rst cyc=%0d got=%h exp=%h", i, obs, exp);
      end
    end
    rst = 1'b1;
    exp_q.push_back(X_IDLE);
    tick();
    exp = exp_q.pop_front();
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL press_rst got=%h exp=%h", obs, exp);
    end
    rst = 1'b0;
    test_evac_timing();
    rst = 1'b1;
    arriving = 1'b0;
    exp_q.push_back(X_IDLE);
    tick();
    exp = exp_q.pop_front();
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL rst_after_evac got=%h exp=%h", obs, exp);
    end
    rst = 1'b0;
  endtask

  // arriving dropped at cycle 5 of EVAC_T.
  task automatic test_abort();
    arriving = 1'b1;
    evac = 1'b1;
    exp_q.push_back(X_EVAC);
    tick();
    evac = 1'b0;
    exp = exp_q.pop_front();
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL abort_start got=%h exp=%h", obs, exp);
    end
    for (int i = 1; i <= 5; i++) begin
      exp_q.push_back(X_EVAC);
      tick();
      exp = exp_q.pop_front();
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL abort_pre cyc=%0d got=%h exp=%h", i, obs, exp);
      end
    end
    arriving = 1'b0;
`ifdef ENTER_ABORT_EN
    exp_q.push_back(X_IDLE);
    tick();
    exp = exp_q.pop_front();
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL abort_idle got=%h exp=%h", obs, exp);
    end
`else
    for (int i = 6; i < 28; i++) begin
      exp_q.push_back(X_EVAC);
      tick();
      exp = exp_q.pop_front();
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL noabort_hold cyc=%0d got=%h exp=%h", i, obs, exp);
      end
    end
    exp_q.push_back(X_OREADY);
    tick();
    exp = exp_q.pop_front();
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL noabort_done got=%h exp=%h", obs, exp);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
`endif
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_start_during_reset();
    test_wrong_order_idle();
    test_evac_timing();
    test_outer_doors();
    test_press_and_inner();
    test_wrong_order_idle();
    test_reset_mid_press();
    test_abort();
    test_reset();
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain left=%0d required=0", exp_q.size());
    end
    checks++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
